// File: rtl/logic_arbiter.sv
// logic_arbiter: two-requester arbiter in front of one shared 4-bit logic unit.
// Each accepted operation takes IDLE -> EXEC -> RESP. The result is held in RESP
// until the consumer takes it.
// Optional feature: define LOGIC_ARB_ROUND_ROBIN_EN to alternate the grant on ties.
// When it is undefined, requester 0 always wins a tie.

module and_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y
);
    assign y = a & b;
endmodule

module or_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y
);
    assign y = a | b;
endmodule

module xor_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] y
);
    assign y = a ^ b;
endmodule

module logic_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [1:0] req0_op,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [1:0] req1_op,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic       res_id,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_t;

    state_t     state;
    op_t        op_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic       id_q;

`ifdef LOGIC_ARB_ROUND_ROBIN_EN
    logic       last_id;
`endif

    logic       grant_valid;
    logic       grant_id;
    logic [1:0] sel_op;
    logic [3:0] sel_a;
    logic [3:0] sel_b;
    logic [3:0] and_y;
    logic [3:0] or_y;
    logic [3:0] xor_y;
    logic [3:0] result;

    // Grant decision: only in IDLE and never while reset is high.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (!reset && state == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant_valid = 1'b1;
`ifdef LOGIC_ARB_ROUND_ROBIN_EN
                grant_id    = ~last_id;
`else
                grant_id    = 1'b0;
`endif
            end else if (req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    assign req0_ready = grant_valid & ~grant_id;
    assign req1_ready = grant_valid &  grant_id;

    assign sel_op = grant_id ? req1_op : req0_op;
    assign sel_a  = grant_id ? req1_a  : req0_a;
    assign sel_b  = grant_id ? req1_b  : req0_b;

    // One shared instance of each unit. The units are fed only from the latched operands.
    and_4bit u_and (.a(a_q), .b(b_q), .y(and_y));
    or_4bit  u_or  (.a(a_q), .b(b_q), .y(or_y));
    xor_4bit u_xor (.a(a_q), .b(b_q), .y(xor_y));

    // Result select. NAND reuses the AND unit and inverts its output.
    always_comb begin
        result = 4'b0000;
        case (op_q)
            OP_AND:  result = and_y;
            OP_OR:   result = or_y;
            OP_XOR:  result = xor_y;
            OP_NAND: result = ~and_y;
            default: result = 4'b0000;
        endcase
    end

    // Control FSM. All of its outputs are registered.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (reset) begin
            state     <= ST_IDLE;
            res_valid <= 1'b0;
            res_data  <= 4'b0000;
            res_id    <= 1'b0;
            busy      <= 1'b0;
            op_q      <= OP_AND;
            a_q       <= 4'b0000;
            b_q       <= 4'b0000;
            id_q      <= 1'b0;
`ifdef LOGIC_ARB_ROUND_ROBIN_EN
            last_id   <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        op_q  <= op_t'(sel_op);
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        id_q  <= grant_id;
                        busy  <= 1'b1;
                        state <= ST_EXEC;
`ifdef LOGIC_ARB_ROUND_ROBIN_EN
                        last_id <= grant_id;
`endif
                    end
                end
                ST_EXEC: begin
                    res_data  <= result;
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_arbiter.sv
// Self-checking bench for logic_arbiter: directed scenarios, an exhaustive
// opcode/operand sweep, and randomized traffic checked against a behavioural model.

module tb_logic_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [1:0] req0_op, req1_op;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       res_valid, res_ready, res_id, busy;
    logic [3:0] res_data;

    int n_checks = 0;
    int n_pass   = 0;
    int ref_last = 1;

    logic_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // Bitwise reference computed with plain integer arithmetic.
    function automatic logic [3:0] ref_op(input int op, input int a, input int b);
        int r;
        case (op)
            0:       r = a & b;
            1:       r = a | b;
            2:       r = a ^ b;
            default: r = 15 - (a & b);
        endcase
        return r[3:0];
    endfunction

    // Requester chosen by the arbitration rule. The caller guarantees that at least one request is valid.
    function automatic int ref_grant(input bit v0, input bit v1, input int last);
        if (v0 && v1) begin
`ifdef LOGIC_ARB_ROUND_ROBIN_EN
            return 1 - last;
`else
            return 0;
`endif
        end
        return v0 ? 0 : 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        tick();
        reset = 1'b0;
        ref_last = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        req0_op = 2'd0; req1_op = 2'd0; req0_a = 4'h0; req0_b = 4'h0; req1_a = 4'h0; req1_b = 4'h0;
        @(negedge clk);
        n_checks++; if ({req1_ready, req0_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {req1_ready, req0_ready}); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if ({req1_ready, req0_ready} !== 2'b00) $display("FAIL reset_ready_hold: got %b want 00", {req1_ready, req0_ready}); else n_pass++;
        n_checks++; if ({res_valid, busy, res_id, res_data} !== 7'b0) $display("FAIL reset_state: got v%b busy%b id%b data%h want all 0", res_valid, busy, res_id, res_data); else n_pass++;
        tick();
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        ref_last = 1;
        @(negedge clk);
        n_checks++; if ({res_valid, busy} !== 2'b00) $display("FAIL reset_idle: got v%b busy%b want 00", res_valid, busy); else n_pass++;
        tick();
    endtask

    task automatic test_single_xor();
        req0_valid = 1'b1; req0_op = 2'b10; req0_a = 4'b1010; req0_b = 4'b0110; res_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({req1_ready, req0_ready, busy} !== 3'b010) $display("FAIL xor_grant: got r1%b r0%b busy%b want 0 1 0", req1_ready, req0_ready, busy); else n_pass++;
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({busy, res_valid} !== 2'b10) $display("FAIL xor_exec: got busy%b v%b want 1 0", busy, res_valid); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if ({res_valid, res_id, res_data} !== 6'b1_0_1100) $display("FAIL xor_result: got v%b id%b data%b want 1 0 1100", res_valid, res_id, res_data); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if ({busy, res_valid} !== 2'b00) $display("FAIL xor_return_idle: got busy%b v%b want 0 0", busy, res_valid); else n_pass++;
        ref_last = 0;
        tick();
    endtask

    task automatic test_alternating();
        int t;
        int exp_id;
        logic [3:0] exp_data;
        do_reset();
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 4'b1111; req0_b = 4'b0011;
        req1_valid = 1'b1; req1_op = 2'b01; req1_a = 4'b1000; req1_b = 4'b0001;
        res_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            t = 1;
            @(negedge clk);
            while (res_valid !== 1'b1 && t < 8) begin
                @(negedge clk);
                t++;
            end
            exp_id   = ref_grant(1'b1, 1'b1, ref_last);
            ref_last = exp_id;
            exp_data = (exp_id == 0) ? 4'b0011 : 4'b1001;
            n_checks++; if (res_valid !== 1'b1) $display("FAIL alt_timeout[%0d]: got res_valid %b want 1", k, res_valid); else n_pass++;
            n_checks++; if ({res_id, res_data} !== {exp_id[0], exp_data}) $display("FAIL alt_result[%0d]: got id%b data%b want id%0d data%b", k, res_id, res_data, exp_id, exp_data); else n_pass++;
            if (k > 0) begin
                n_checks++; if (t != 3) $display("FAIL alt_interval[%0d]: got %0d cycles want 3", k, t); else n_pass++;
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req1_valid = 1'b1; req1_op = 2'b11; req1_a = 4'b1100; req1_b = 4'b1010; res_ready = 1'b0;
        @(negedge clk);
        n_checks++; if ({req1_ready, req0_ready} !== 2'b10) $display("FAIL bp_grant1: got %b want 10", {req1_ready, req0_ready}); else n_pass++;
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 4'h3; req0_b = 4'h4;
        @(negedge clk);
        n_checks++; if (req0_ready !== 1'b0) $display("FAIL bp_exec_ready0: got %b want 0", req0_ready); else n_pass++;
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if ({res_valid, res_id, res_data, req0_ready} !== 7'b1_1_0111_0) $display("FAIL bp_hold[%0d]: got v%b id%b data%b r0%b want 1 1 0111 0", k, res_valid, res_id, res_data, req0_ready); else n_pass++;
            tick();
        end
        res_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({res_valid, req0_ready} !== 2'b10) $display("FAIL bp_release: got v%b r0%b want 1 0", res_valid, req0_ready); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if ({busy, req0_ready} !== 2'b01) $display("FAIL bp_idle_resume: got busy%b r0%b want 0 1", busy, req0_ready); else n_pass++;
        tick();
        req0_valid = 1'b0;
        ref_last = 0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset_mid();
        logic seen;
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 4'b1111; req0_b = 4'b0000; res_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (req0_ready !== 1'b1) $display("FAIL rmid_grant: got %b want 1", req0_ready); else n_pass++;
        tick();
        reset = 1'b1; req0_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL rmid_exec: got busy %b want 1", busy); else n_pass++;
        tick();
        reset = 1'b0;
        ref_last = 1;
        @(negedge clk);
        n_checks++; if ({res_valid, busy, res_id, res_data} !== 7'b0) $display("FAIL rmid_cleared: got v%b busy%b id%b data%b want all 0", res_valid, busy, res_id, res_data); else n_pass++;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            if (res_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL rmid_no_response: got a response flag %b want 0", seen); else n_pass++;
        tick();
    endtask

    task automatic test_sweep();
        int t;
        logic [3:0] exp_data;
        do_reset();
        res_ready = 1'b1;
        for (int op = 0; op < 4; op++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    req0_valid = 1'b1; req0_op = op[1:0]; req0_a = a[3:0]; req0_b = b[3:0];
                    exp_data = ref_op(op, a, b);
                    t = 0;
                    @(negedge clk);
                    while (req0_ready !== 1'b1 && t < 4) begin
                        @(negedge clk);
                        t++;
                    end
                    n_checks++; if (req0_ready !== 1'b1) $display("FAIL sweep_accept op%0d a%h b%h: got ready %b want 1", op, a, b, req0_ready); else n_pass++;
                    tick();
                    req0_valid = 1'b0;
                    t = 0;
                    @(negedge clk);
                    while (res_valid !== 1'b1 && t < 4) begin
                        @(negedge clk);
                        t++;
                    end
                    n_checks++; if ({res_valid, res_id, res_data} !== {2'b10, exp_data}) $display("FAIL sweep_result op%0d a%h b%h: got v%b id%b data%b want 1 0 %b", op, a, b, res_valid, res_id, res_data, exp_data); else n_pass++;
                    tick();
                end
            end
        end
        ref_last = 0;
    endtask

    task automatic test_random();
        bit         v[2];
        bit         hold[2];
        int         op[2], a[2], b[2];
        bit         m_inflight;
        int         m_age, g;
        logic [3:0] m_data;
        int         m_id;
        logic [1:0] exp_rdy;
        do_reset();
        hold[0] = 0; hold[1] = 0;
        m_inflight = 0; m_age = 0; m_data = 4'h0; m_id = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 2; i++) begin
                if (!hold[i]) begin
                    v[i]  = ($urandom_range(0, 2) != 0);
                    op[i] = $urandom_range(0, 3);
                    a[i]  = $urandom_range(0, 15);
                    b[i]  = $urandom_range(0, 15);
                end
            end
            req0_valid = v[0]; req0_op = op[0][1:0]; req0_a = a[0][3:0]; req0_b = b[0][3:0];
            req1_valid = v[1]; req1_op = op[1][1:0]; req1_a = a[1][3:0]; req1_b = b[1][3:0];
            @(negedge clk);
            g = -1;
            if (!m_inflight) begin
                exp_rdy = 2'b00;
                if (v[0] || v[1]) begin
                    g = ref_grant(v[0], v[1], ref_last);
                    exp_rdy[g] = 1'b1;
                end
                n_checks++; if ({req1_ready, req0_ready} !== exp_rdy) $display("FAIL rnd_grant c%0d: got %b want %b", cyc, {req1_ready, req0_ready}, exp_rdy); else n_pass++;
                n_checks++; if ({res_valid, busy} !== 2'b00) $display("FAIL rnd_idle c%0d: got v%b busy%b want 0 0", cyc, res_valid, busy); else n_pass++;
                if (g >= 0) begin
                    m_inflight = 1; m_age = 0; m_id = g; ref_last = g;
                    m_data = ref_op(op[g], a[g], b[g]);
                end
            end else begin
                m_age++;
                n_checks++; if ({req1_ready, req0_ready, busy} !== 3'b001) $display("FAIL rnd_busy c%0d: got r1%b r0%b busy%b want 0 0 1", cyc, req1_ready, req0_ready, busy); else n_pass++;
                if (m_age == 1) begin
                    n_checks++; if (res_valid !== 1'b0) $display("FAIL rnd_exec c%0d: got v%b want 0", cyc, res_valid); else n_pass++;
                end else begin
                    n_checks++; if ({res_valid, res_id, res_data} !== {1'b1, m_id[0], m_data}) $display("FAIL rnd_result c%0d: got v%b id%b data%b want 1 %0d %b", cyc, res_valid, res_id, res_data, m_id, m_data); else n_pass++;
                    if (res_ready) m_inflight = 0;
                end
            end
            for (int i = 0; i < 2; i++) hold[i] = v[i] && (g != i);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        tick(); tick(); tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_xor();
        test_alternating();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/logic_arbiter.md
LOGIC_ARBITER -- requirements
Module: logic_arbiter

Interface
REQ-001 No parameters; datapath width is fixed at 4 bits.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 REQ0_VALID  input  1  requester 0 has an operation pending.
REQ-005 REQ0_READY  output  1  requester 0 operation accepted this cycle.
REQ-006 REQ0_OP  input  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-007 REQ0_A, REQ0_B  input  4 each  requester 0 operands.
REQ-008 REQ1_VALID, REQ1_READY, REQ1_OP, REQ1_A, REQ1_B  same as REQ-004..007, for requester 1.
REQ-009 RES_VALID  output  1  result available.
REQ-010 RES_READY  input  1  consumer accepts result.
REQ-011 RES_DATA  output  4  operation result.
REQ-012 RES_ID  output  1  index of requester that issued the result.
REQ-013 BUSY  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 Block shall share a single instance each of And_4bit, Or_4bit and Xor_4bit between the two requesters; NAND = bitwise inverse of the And_4bit output.
REQ-015 FSM states: IDLE, EXEC, RESP; encoding is free.
REQ-016 IDLE: if any REQx_VALID is high, grant one requester, assert its REQx_READY combinationally that cycle, latch OP/A/B/ID, go to EXEC; otherwise stay in IDLE.
REQ-017 REQx_READY shall be high only in IDLE and only for the granted requester; never for both in the same cycle.
REQ-018 EXEC: register the selected result into RES_DATA and the ID into RES_ID; go to RESP (exactly one cycle).
REQ-019 RESP: RES_VALID high; RES_DATA/RES_ID held stable until RES_READY is high; on RES_READY go to IDLE.
REQ-020 Latency: operation accepted at edge N produces RES_VALID from edge N+2; with RES_READY tied high, minimum issue interval is 3 cycles.
REQ-021 Requests arriving while BUSY are not accepted; the requester holds VALID and operands stable until READY (protocol rule, not checked).
REQ-022 Arithmetic: result is purely bitwise on 4 bits; no carry or overflow output.
REQ-023 Grant pointer (last-granted ID) updates only on acceptance.

Reset
REQ-024 RESET high at any edge forces: state IDLE, RES_VALID 0, RES_DATA 0000, RES_ID 0, last-granted pointer 1, BUSY 0.
REQ-025 RESET during EXEC or RESP discards the in-flight operation; no result is delivered for it.
REQ-026 While RESET is high, REQ0_READY and REQ1_READY shall be 0.

Configuration
REQ-027 Macro LOGIC_ARB_ROUND_ROBIN_EN defined: when both VALID in IDLE, grant the requester not granted last; single VALID is always granted.
REQ-028 Macro LOGIC_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins ties; pointer may be omitted.

Verification
REQ-029 Reset then REQ0 XOR A=1010 B=0110 alone -> REQ0_READY at cycle 0, RES_VALID at cycle 2 with RES_DATA=1100, RES_ID=0.
REQ-030 Both VALID continuously, REQ0 AND 1111/0011, REQ1 OR 1000/0001, RES_READY=1 -> round-robin build: results 0011(ID0), 1001(ID1), 0011(ID0) alternating; fixed-priority build: ID0 only.
REQ-031 REQ1 NAND A=1100 B=1010, RES_READY low 4 cycles -> RES_DATA=0111, RES_ID=1 stable all 4 cycles; REQ0 VALID meanwhile sees READY=0; IDLE resumes cycle after RES_READY.
REQ-032 Exhaustive sweep: all 4 opcodes x 256 operand pairs via REQ0 -> every RES_DATA equals bitwise reference; no mismatches.
REQ-033 RESET asserted during EXEC -> next cycle RES_VALID=0, BUSY=0, RES_DATA=0000; no response appears for the discarded operation.
